// File: rtl/fir_pkg.sv
// Shared state encoding and width helpers for the serial FIR MAC datapath.
package fir_pkg;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;

    function automatic int unsigned fir_prod_width(int unsigned dw, int unsigned cw);
        return dw + cw;
    endfunction

    function automatic int unsigned fir_acc_width(int unsigned dw, int unsigned cw,
                                                  int unsigned taps);
        return dw + cw + $clog2(taps);
    endfunction

    // Default configuration and the widths/constants derived from it.
    localparam int unsigned DATA_WIDTH_DEF = 12;
    localparam int unsigned COEF_WIDTH_DEF = 12;
    localparam int unsigned FRAC_BITS_DEF  = 11;
    localparam int unsigned NUM_TAPS_DEF   = 8;
    localparam int unsigned NUM_STAGES_DEF = 2;

    localparam int unsigned PROD_WIDTH  = fir_prod_width(DATA_WIDTH_DEF, COEF_WIDTH_DEF);
    localparam int unsigned ACC_WIDTH   = fir_acc_width(DATA_WIDTH_DEF, COEF_WIDTH_DEF,
                                                        NUM_TAPS_DEF);
    localparam int unsigned ADDR_WIDTH  = $clog2(NUM_TAPS_DEF);
    localparam int unsigned ROUND_CONST = 1 << (FRAC_BITS_DEF - 1);
    localparam int          SAT_MAX     = (1 << (DATA_WIDTH_DEF - 1)) - 1;
    localparam int          SAT_MIN     = -(1 << (DATA_WIDTH_DEF - 1));

endpackage

// File: rtl/coef_regfile.sv
// Run-time writable coefficient store; writes are locked out while a result is in flight.
module coef_regfile #(
    parameter int unsigned NUM_TAPS   = 8,
    parameter int unsigned COEF_WIDTH = 12,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  busy,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [COEF_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [COEF_WIDTH-1:0] rdata
);

    logic [COEF_WIDTH-1:0] regs [NUM_TAPS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && !busy && (32'(waddr) < NUM_TAPS)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = regs[raddr];

endmodule

// File: rtl/load_sync.sv
// Multi-flop synchroniser for the asynchronous sample strobe.
module load_sync #(
    parameter int unsigned NUM_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [NUM_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < NUM_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/fir_mac_serial.sv
// Time-multiplexed FIR: one multiplier and one accumulator, one tap per clock,
// per-tap round-half-up and a saturated output register.
module fir_mac_serial
    import fir_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned COEF_WIDTH = COEF_WIDTH_DEF,
    parameter int unsigned FRAC_BITS  = FRAC_BITS_DEF,
    parameter int unsigned NUM_TAPS   = NUM_TAPS_DEF,
    parameter int unsigned NUM_STAGES = NUM_STAGES_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_in,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        coef_we,
    input  logic [$clog2(NUM_TAPS)-1:0] coef_addr,
    input  logic [COEF_WIDTH-1:0]       coef_wdata,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        out_valid,
    output logic                        busy,
    output logic                        overrun
);

    localparam int unsigned PW = fir_prod_width(DATA_WIDTH, COEF_WIDTH);
    localparam int unsigned AW = fir_acc_width(DATA_WIDTH, COEF_WIDTH, NUM_TAPS);
    localparam int unsigned KW = $clog2(NUM_TAPS);

    localparam logic signed [PW:0]   RND    = (PW + 1)'(1) << (FRAC_BITS - 1);
    localparam logic signed [AW-1:0] SAT_HI = {{(AW - DATA_WIDTH + 1){1'b0}},
                                               {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_LO = ~SAT_HI;

    state_e                       state_q;
    logic signed [DATA_WIDTH-1:0] x_q [NUM_TAPS];
    logic signed [AW-1:0]         acc_q;
    logic [KW-1:0]                k_q;
    logic                         sync, sync_d, load_rise;

    logic signed [COEF_WIDTH-1:0] coef_k;
    logic signed [PW-1:0]         prod;
    logic signed [PW:0]           prod_rnd, prod_shr;
    logic signed [AW-1:0]         term;
    logic signed [DATA_WIDTH-1:0] y_sat;

    load_sync #(
        .NUM_STAGES (NUM_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (load_in),
        .q     (sync)
    );

    coef_regfile #(
        .NUM_TAPS   (NUM_TAPS),
        .COEF_WIDTH (COEF_WIDTH),
        .ADDR_WIDTH (KW)
    ) u_coef (
        .clk   (clk),
        .rst_n (rst_n),
        .busy  (busy),
        .we    (coef_we),
        .waddr (coef_addr),
        .wdata (coef_wdata),
        .raddr (k_q),
        .rdata (coef_k)
    );

    assign load_rise = sync & ~sync_d;
    assign busy      = (state_q != IDLE);

    // Rounding is applied to every tap product before it is scaled back down.
    assign prod     = PW'(coef_k) * PW'(x_q[k_q]);
    assign prod_rnd = (PW + 1)'(prod) + RND;
    assign prod_shr = prod_rnd >>> FRAC_BITS;
    assign term     = AW'(prod_shr);

    always_comb begin
        y_sat = acc_q[DATA_WIDTH-1:0];
        if (acc_q > SAT_HI) begin
            y_sat = SAT_HI[DATA_WIDTH-1:0];
        end else if (acc_q < SAT_LO) begin
            y_sat = SAT_LO[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            k_q       <= '0;
            sync_d    <= 1'b0;
            data_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            sync_d    <= sync;
            out_valid <= 1'b0;
            if (load_rise && busy) begin
                overrun <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (load_rise) begin
                        x_q[0] <= data_in;
                        for (int i = 1; i < NUM_TAPS; i++) begin
                            x_q[i] <= x_q[i-1];
                        end
                        acc_q   <= '0;
                        k_q     <= '0;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_q + term;
                    if (k_q == KW'(NUM_TAPS - 1)) begin
                        state_q <= DONE;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                DONE: begin
                    data_out  <= y_sat;
                    out_valid <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fir_mac_serial.md
# fir_mac_serial

- Parametrised, time-multiplexed FIR filter with one multiplier and one accumulator.
- On each synchronised `load_in` rising edge, it captures one sample, then computes y = Σ c[k]·x[n−k] over NUM_TAPS taps, one tap per cycle.
- The result is rounded and saturated to Q(DATA_WIDTH−FRAC_BITS).FRAC_BITS, then presented with a one-cycle `out_valid` strobe.
- Coefficients are run-time writable, replacing fixed coefficient storage.
- The block sits between the asynchronous sample source and downstream sample consumers.

## Interface
- DATA_WIDTH, 12, sample and output width (signed).
- COEF_WIDTH, 12, coefficient width (signed).
- FRAC_BITS, 11, fractional bits of the coefficients; the product is shifted right by this amount.
- NUM_TAPS, 8, filter length, ≥2 (power of two not required).
- NUM_STAGES, 2, depth of the `load_in` synchroniser.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- load_in  in  1  asynchronous sample strobe; must be held ≥NUM_STAGES+1 cycles.
- data_in  in  DATA_WIDTH  signed sample; stable from `load_in` rise until `busy` rises.
- coef_we  in  1  coefficient write enable.
- coef_addr  in  $clog2(NUM_TAPS)  coefficient index k.
- coef_wdata  in  COEF_WIDTH  signed coefficient value.
- data_out  out  DATA_WIDTH  signed filtered sample; holds its value between results.
- out_valid  out  1  one-cycle pulse when `data_out` updates.
- busy  out  1  high while state ≠ IDLE.
- overrun  out  1  sticky flag, set when a load is dropped; cleared only by reset.

## Operation
- Synchroniser: NUM_STAGES flops, then an edge-detect flop. `load_rise` = sync & ~sync_d.
- Delay line x[0..NUM_TAPS−1] (x[0] newest), captured on accepted `load_rise`: x[0]←data_in, x[k]←x[k−1].
- FSM states: IDLE, MAC, DONE.
  - IDLE→MAC on `load_rise`. Also clears acc and sets tap index k=0.
  - MAC: acc += (c[k]·x[k]) >>> FRAC_BITS (arithmetic shift), then k++.
  - MAC→DONE after the k=NUM_TAPS−1 accumulate.
  - DONE→IDLE always. On this transition: data_out←sat(round), out_valid←1.
- Product width: DATA_WIDTH+COEF_WIDTH. Accumulator width: DATA_WIDTH+COEF_WIDTH+$clog2(NUM_TAPS); it never wraps.
- Rounding is round-half-up: add 2^(FRAC_BITS−1) to the full product before the shift.
- Saturation clamps to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- `load_rise` while `busy`: the sample is dropped, the delay line is unchanged, and `overrun`←1.
- Coefficient write in IDLE: c[coef_addr]←coef_wdata at the clock edge. A write with `busy` high is ignored.
- A coefficient write in the same cycle as `load_rise` (IDLE) is accepted, and the new value is used by this computation.
- Reset (rst_n=0 at an edge) clears the following, even mid-MAC with no output produced:
  - delay line, coefficients, acc, k, data_out, synchroniser and edge flops: 0
  - out_valid=0, busy=0, overrun=0, state=IDLE

## Timing
- Cycle T is the cycle in which `load_rise`=1. `load_in` rise to `load_rise` takes NUM_STAGES+1 clocks.
- Edge at end of T: sample captured, `busy`=1 from T+1.
- Edges at end of T+1..T+NUM_TAPS: accumulate taps 0..NUM_TAPS−1.
- Edge at end of T+NUM_TAPS+1 (DONE): `data_out` and `out_valid` visible in cycle T+NUM_TAPS+2.
- Also in cycle T+NUM_TAPS+2, `busy`=0.
- `load_rise` in cycle T+NUM_TAPS+2 is accepted (back-to-back). The minimum sample spacing is NUM_TAPS+2 cycles.
- out_valid lasts exactly 1 cycle. data_out changes only at that edge or at reset.

## Structure
- Shared package `fir_pkg`:
  - state enum {IDLE, MAC, DONE}
  - localparams ACC_WIDTH, PROD_WIDTH, ADDR_WIDTH
  - round constant 2^(FRAC_BITS−1)
  - saturation limits
- Sub-module `coef_regfile`: NUM_TAPS×COEF_WIDTH registers, synchronous write gated by `!busy`, combinational read at k, synchronous reset to 0.
- Synchroniser: the team's existing `load_sync` block instantiated with NUM_STAGES.
- Top level holds the FSM, delay line, MAC and output register.

## Test plan
All scenarios use defaults (12/12/11/8/2).
- Impulse response: c[k]=0x100·k, then samples 0x400, 0,0,…
  - Successive outputs 0x000,0x080,0x100,…,0x380, one out_valid per sample.
- Rounding: c[0]=0x001, others 0, x=0x400.
  - Output 0x001 (0.5 LSB rounds up).
  - With x=0xC00, output 0x000.
- Saturation: all c=0x7FF, eight samples of 0x7FF, then the ninth output.
  - Output 0x7FF.
  - With all samples 0x800, output 0x800.
- Overrun: second `load_in` pulse arriving with `busy` high (e.g., `load_rise` at T+3).
  - overrun=1 sticky, the sample is dropped, and the next output is identical to the no-overrun run.
- Coefficient write while busy: write c[0]=0x7FF during MAC.
  - The current and next outputs use the old c[0]. An IDLE write takes effect on the following load.
- Reset mid-MAC: rst_n=0 one cycle at T+4.
  - No out_valid, and all outputs/flags are 0.
  - The next load computes y=c[0]·x with a zeroed history (coefficients reset to 0, so data_out=0 until rewritten).
